// File: rtl/bin_to_bcd_converter_pkg.sv
// Shared constants for the binary-to-BCD converter and the seven-segment
// display path that consumes its output.
package bin_to_bcd_converter_pkg;

  // Nibble shown on every digit when the value does not fit the display.
  localparam logic [3:0] BCD_ERR_NIBBLE = 4'hE;

  // FSM state encodings.
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  // Digit count of the display driver; the converter output must match it.
  localparam int DISPLAY_DIGITS = 8;

  // Number of BCD digits needed to hold any unsigned value of the given width.
  function automatic int scr_digits(input int bin_width);
    return (bin_width * 3) / 10 + 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_converter_bcd_digit_adjust.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Incoming nibbles are always 0..9, so the 4-bit add never carries out.
  assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble converter: one input bit per clock, start/busy/done
// handshake, result (or error pattern on overflow) held until the next completion.
module bin_to_bcd_converter
  import bin_to_bcd_converter_pkg::*;
#(
  parameter int BIN_WIDTH = 32,
  parameter int DIGITS    = DISPLAY_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int SCR_DIGITS = scr_digits(BIN_WIDTH);
  localparam int SCR_W      = SCR_DIGITS * 4;
  localparam int CNT_W      = $clog2(BIN_WIDTH + 1);

  logic [0:0]           state;
  logic [CNT_W-1:0]     counter;
  logic [BIN_WIDTH-1:0] shreg;
  logic [SCR_W-1:0]     scratch;
  logic [SCR_W-1:0]     scratch_adj;
  logic [SCR_W-1:0]     scratch_next;
  logic                 scratch_unused_msb;
  logic [DIGITS*4-1:0]  load_bcd;
  logic                 load_ovf;

  // Per-digit +3 correction applied to the current scratch before shifting.
  for (genvar d = 0; d < SCR_DIGITS; d++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit_in  (scratch[d*4 +: 4]),
      .digit_out (scratch_adj[d*4 +: 4])
    );
  end

  // The top bit shifted out of the scratch is always zero because SCR_DIGITS
  // is sized for the largest input.
  assign scratch_unused_msb = scratch_adj[SCR_W-1];
  assign scratch_next       = {scratch_adj[SCR_W-2:0], shreg[BIN_WIDTH-1]};

  // Result selection from the post-shift scratch, so the final edge of the
  // conversion can load the outputs directly.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (latch).
    load_ovf = 1'b0;
    load_bcd = '0;
    for (int d = DIGITS; d < SCR_DIGITS; d++) begin
      if (scratch_next[d*4 +: 4] != 4'd0) load_ovf = 1'b1;
    end
    if (load_ovf) begin
      load_bcd = {DIGITS{BCD_ERR_NIBBLE}};
    end else begin
      for (int d = 0; d < DIGITS; d++) begin
        if (d < SCR_DIGITS) load_bcd[d*4 +: 4] = scratch_next[d*4 +: 4];
      end
    end
  end

  // FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      counter  <= '0;
      shreg    <= '0;
      scratch  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            shreg   <= bin_in;
            scratch <= '0;
            counter <= CNT_W'(BIN_WIDTH);
            busy    <= 1'b1;
            state   <= S_CONV;
          end
        end
        S_CONV: begin
          scratch <= scratch_next;
          shreg   <= {shreg[BIN_WIDTH-2:0], 1'b0};
          counter <= counter - CNT_W'(1);
          if (counter == CNT_W'(1)) begin
            bcd_out  <= load_bcd;
            overflow <= load_ovf;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
